// File: rtl/rec_mult_pkg.sv
// Shared constants, FSM encoding and shift helper for the recursive approximate multiplier.
package rec_mult_pkg;

    localparam int CORE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Weight of partial product k: a nibble i = k%n, b nibble j = k/n.
    function automatic int step_shift(input int k, input int n);
        return CORE_W * ((k % n) + (k / n));
    endfunction

endpackage

// File: rtl/Reh4.sv
// 4x4 approximate multiplier: four 2x2 blocks, each exact except 3*3 which yields 7.
module Reh4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] y
);

    function automatic logic [2:0] mul2(input logic [1:0] x, input logic [1:0] z);
        if (x == 2'd3 && z == 2'd3) return 3'd7;
        return {1'b0, x} * {1'b0, z};
    endfunction

    always_comb begin
        y = 8'(mul2(a[1:0], b[1:0]))
          + (8'(mul2(a[3:2], b[1:0])) << 2)
          + (8'(mul2(a[1:0], b[3:2])) << 2)
          + (8'(mul2(a[3:2], b[3:2])) << 4);
    end

endmodule

// File: rtl/pp_nibble_sel.sv
// Selects the a/b nibbles for a step and forms their partial product.
// REC_MULT_EXACT_MSB_EN: the final (most significant) step uses an exact 4x4 multiply.
module pp_nibble_sel
    import rec_mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 2
) (
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [STEP_W-1:0]   step_i,
    output logic [2*CORE_W-1:0] pp_o
);

    localparam int N = WIDTH / CORE_W;

    logic [CORE_W-1:0]   a_nib;
    logic [CORE_W-1:0]   b_nib;
    logic [2*CORE_W-1:0] approx;

    always_comb begin
        a_nib = a_i[CORE_W*(int'(step_i) % N) +: CORE_W];
        b_nib = b_i[CORE_W*(int'(step_i) / N) +: CORE_W];
    end

    Reh4 u_core (
        .a (a_nib),
        .b (b_nib),
        .y (approx)
    );

`ifdef REC_MULT_EXACT_MSB_EN
    always_comb begin
        if (step_i == STEP_W'(N*N-1)) pp_o = {4'b0, a_nib} * {4'b0, b_nib};
        else                          pp_o = approx;
    end
`else
    assign pp_o = approx;
`endif

endmodule

// File: rtl/rec_mult_sequencer.sv
// Multi-cycle WIDTHxWIDTH approximate multiplier: one nibble product per cycle, shift-accumulated.
// Optional REC_MULT_EXACT_MSB_EN makes the top nibble product exact (see pp_nibble_sel).
module rec_mult_sequencer
    import rec_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int N      = WIDTH / CORE_W;
    localparam int NSTEP  = N * N;
    localparam int STEP_W = $clog2(NSTEP);
    localparam logic [STEP_W-1:0] LAST = STEP_W'(NSTEP - 1);

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [2*WIDTH-1:0]  acc_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [2*CORE_W-1:0] pp;

    pp_nibble_sel #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_sel (
        .a_i    (a_q),
        .b_i    (b_q),
        .step_i (step_q),
        .pp_o   (pp)
    );

    // Core output <= 225, so the full sum always fits in 2*WIDTH bits.
    assign acc_d = acc_q + ((2*WIDTH)'(pp) << step_shift(int'(step_q), N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == LAST) begin
                        step_q      <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = acc_q;

endmodule
